// File: rtl/freq_count_latch.sv
// Measurement counter for the frequency meter: synchronises CPx, counts its rising
// edges in BCD while gated, and latches the count/overflow for the display stage.
module freq_count_latch #(
  parameter int DIGITS      = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                CLK_50,
  input  logic                RST,
  input  logic                CPx,
  input  logic                C_Enable,
  input  logic                C_Clear,
  input  logic                C_Store,
  output logic                OF,
  output logic [4*DIGITS-1:0] Data_BCD,
  output logic                Data_OF,
  output logic                Data_Valid
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_prev_q, sync_prev_d;
  logic [4*DIGITS-1:0]    cnt_q, cnt_d;
  logic                   of_q, of_d;
  logic [4*DIGITS-1:0]    data_bcd_q, data_bcd_d;
  logic                   data_of_q, data_of_d;
  logic                   data_valid_q, data_valid_d;
  logic                   store_prev_q, store_prev_d;

  logic                   cpx_rise;
  logic                   inc;
  logic                   store_rise;
  logic [DIGITS:0]        nines;
  logic [4*DIGITS-1:0]    cnt_inc;

  // nines[k] is high when digits 0..k-1 are all 9, i.e. digit k receives a carry.
  assign nines[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] dig;
      assign dig            = cnt_q[4*gi +: 4];
      assign nines[gi+1]    = nines[gi] & (dig == 4'd9);
      assign cnt_inc[4*gi +: 4] = !nines[gi]      ? dig  :
                                  (dig == 4'd9)   ? 4'd0 :
                                                    dig + 4'd1;
    end
  endgenerate

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], CPx};
    sync_prev_d  = sync_q[SYNC_STAGES-1];
    cpx_rise     = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
    inc          = cpx_rise & C_Enable;
    store_rise   = C_Store & ~store_prev_q;
    store_prev_d = C_Store;

    cnt_d = cnt_q;
    of_d  = of_q;
    if (C_Clear) begin
      cnt_d = '0;
      of_d  = 1'b0;
    end else if (inc) begin
      // At all-9s the counter saturates instead of wrapping to zero.
      if (nines[DIGITS]) begin
        of_d = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end

    // The latch samples the registered (pre-update) count, so a coincident
    // increment or clear never leaks into the stored value.
    data_bcd_d   = data_bcd_q;
    data_of_d    = data_of_q;
    data_valid_d = store_rise;
    if (store_rise) begin
      data_bcd_d = cnt_q;
      data_of_d  = of_q;
    end
  end

  always_ff @(posedge CLK_50) begin
    if (RST) begin
      sync_q       <= '0;
      sync_prev_q  <= 1'b0;
      cnt_q        <= '0;
      of_q         <= 1'b0;
      data_bcd_q   <= '0;
      data_of_q    <= 1'b0;
      data_valid_q <= 1'b0;
      store_prev_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      sync_prev_q  <= sync_prev_d;
      cnt_q        <= cnt_d;
      of_q         <= of_d;
      data_bcd_q   <= data_bcd_d;
      data_of_q    <= data_of_d;
      data_valid_q <= data_valid_d;
      store_prev_q <= store_prev_d;
    end
  end

  assign OF         = of_q;
  assign Data_BCD   = data_bcd_q;
  assign Data_OF    = data_of_q;
  assign Data_Valid = data_valid_q;

endmodule

// File: tb/tb_freq_count_latch.sv
// Bench for freq_count_latch: directed vector table and corner sequences plus random
// traffic, all checked every cycle against an integer-valued reference model.
module tb_freq_count_latch;
  localparam int DIGITS = 4;
  localparam int SS     = 2;
  localparam int MAXV   = 9999;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cpx = 1'b0;
  logic                en  = 1'b0;
  logic                clr = 1'b0;
  logic                st  = 1'b0;
  logic                of_o;
  logic [4*DIGITS-1:0] data_bcd;
  logic                data_of;
  logic                data_valid;

  freq_count_latch #(.DIGITS(DIGITS), .SYNC_STAGES(SS)) dut (
    .CLK_50    (clk),
    .RST       (rst),
    .CPx       (cpx),
    .C_Enable  (en),
    .C_Clear   (clr),
    .C_Store   (st),
    .OF        (of_o),
    .Data_BCD  (data_bcd),
    .Data_OF   (data_of),
    .Data_Valid(data_valid)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int valid_seen;

  // Reference model: count as a plain integer, CPx history as a sample queue.
  int m_cnt, m_of, m_bcd, m_dof, m_valid, m_stprev;
  int hist[$];

  typedef struct {
    int                  n;
    int                  hi;
    int                  lo;
    logic [4*DIGITS-1:0] exp_bcd;
    logic                exp_of;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [4*DIGITS-1:0] to_bcd(int v);
    logic [4*DIGITS-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit rise;
    bit srise;
    if (rst) begin
      hist.delete();
      repeat (SS + 1) hist.push_back(0);
      m_cnt = 0; m_of = 0; m_bcd = 0; m_dof = 0; m_valid = 0; m_stprev = 0;
    end else begin
      hist.push_back(int'(cpx));
      while (hist.size() > SS + 2) void'(hist.pop_front());
      rise  = (hist.size() == SS + 2) && hist[1] == 1 && hist[0] == 0;
      srise = st && !m_stprev;
      m_valid = srise;
      if (srise) begin
        m_bcd = m_cnt;
        m_dof = m_of;
      end
      m_stprev = st;
      if (clr) begin
        m_cnt = 0;
        m_of  = 0;
      end else if (rise && en) begin
        if (m_cnt == MAXV) m_of = 1;
        else m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic step();
    bit bad;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("OF", 64'(of_o), 64'(m_of));
    check("Data_BCD", 64'(data_bcd), 64'(to_bcd(m_bcd)));
    check("Data_OF", 64'(data_of), 64'(m_dof));
    check("Data_Valid", 64'(data_valid), 64'(m_valid));
    bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) if (data_bcd[4*k +: 4] > 4'd9) bad = 1'b1;
    check("bcd_digit_range", 64'(bad), 64'd0);
    if (data_valid) valid_seen++;
  endtask

  task automatic count_edges(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      cpx = 1'b1;
      repeat (hi) step();
      cpx = 1'b0;
      repeat (lo) step();
    end
  endtask

  task automatic do_clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic store(input int len);
    valid_seen = 0;
    st = 1'b1;
    repeat (len) step();
    st = 1'b0;
    repeat (2) step();
  endtask

  task automatic expect_store(input string name, input logic [4*DIGITS-1:0] bcd, input logic ofl);
    store(3);
    check({name, "_bcd"}, 64'(data_bcd), 64'(bcd));
    check({name, "_of"}, 64'(data_of), 64'(ofl));
    check({name, "_valid_pulses"}, 64'(valid_seen), 64'd1);
    $display("seq %s: Data_BCD=%h Data_OF=%0d", name, data_bcd, data_of);
  endtask

  initial begin
    vecs[0] = '{137, 25, 25, 16'h0137, 1'b0};
    vecs[1] = '{5,   2,  2,  16'h0005, 1'b0};
    vecs[2] = '{10,  3,  2,  16'h0010, 1'b0};
    vecs[3] = '{99,  2,  3,  16'h0099, 1'b0};
    vecs[4] = '{100, 2,  2,  16'h0100, 1'b0};

    // Reset held three cycles with CPx toggling and the gate open.
    rst = 1'b1; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpx = i[0];
      step();
      check("reset_bcd", 64'(data_bcd), 64'd0);
      check("reset_of", 64'(of_o), 64'd0);
      check("reset_valid", 64'(data_valid), 64'd0);
    end
    rst = 1'b0; cpx = 1'b0; en = 1'b0;
    step();
    expect_store("after_reset", 16'h0000, 1'b0);

    // Vector table: clear, gated count, close gate, long store.
    for (int v = 0; v < 5; v++) begin
      do_clear();
      en = 1'b1;
      count_edges(vecs[v].n, vecs[v].hi, vecs[v].lo);
      repeat (4) step();
      en = 1'b0;
      step();
      store(5);
      check("vec_bcd", 64'(data_bcd), 64'(vecs[v].exp_bcd));
      check("vec_of", 64'(data_of), 64'(vecs[v].exp_of));
      check("vec_valid_pulses", 64'(valid_seen), 64'd1);
      $display("vec %0d: edges=%0d Data_BCD=%h Data_OF=%0d pulses=%0d",
               v, vecs[v].n, data_bcd, data_of, valid_seen);
    end

    // Gate discard: the rise lands on the first cycle with the gate closed.
    do_clear();
    en = 1'b1;
    count_edges(3, 2, 2);
    repeat (3) step();
    cpx = 1'b1; step(); step();
    en = 1'b0; step();
    cpx = 1'b0; repeat (3) step();
    expect_store("gate_discard", 16'h0003, 1'b0);

    // Same position but gate still open on the rise cycle: counted.
    do_clear();
    en = 1'b1;
    count_edges(3, 2, 2);
    repeat (3) step();
    cpx = 1'b1; step(); step(); step();
    en = 1'b0;
    cpx = 1'b0; repeat (3) step();
    expect_store("gate_last", 16'h0004, 1'b0);

    // Store and clear rising together at 42.
    do_clear();
    en = 1'b1;
    count_edges(42, 2, 2);
    repeat (3) step();
    en = 1'b0;
    st = 1'b1; clr = 1'b1;
    step();
    st = 1'b0; clr = 1'b0;
    step();
    check("store_clear_bcd", 64'(data_bcd), 64'h0042);
    $display("seq store_clear: Data_BCD=%h", data_bcd);
    expect_store("after_store_clear", 16'h0000, 1'b0);

    // Increment and store in the same cycle.
    do_clear();
    en = 1'b1;
    count_edges(7, 2, 2);
    repeat (3) step();
    cpx = 1'b1; step(); step();
    st = 1'b1; step();
    st = 1'b0; cpx = 1'b0;
    step();
    check("store_inc_bcd", 64'(data_bcd), 64'h0007);
    $display("seq store_inc: Data_BCD=%h", data_bcd);
    repeat (3) step();
    en = 1'b0;
    expect_store("after_store_inc", 16'h0008, 1'b0);

    // Decade carry, then run to full scale and overflow.
    do_clear();
    en = 1'b1;
    count_edges(999, 2, 2);
    repeat (3) step();
    expect_store("carry_999", 16'h0999, 1'b0);
    count_edges(1, 2, 2);
    repeat (3) step();
    expect_store("carry_1000", 16'h1000, 1'b0);
    count_edges(8999, 2, 2);
    repeat (3) step();
    check("full_scale_of", 64'(of_o), 64'd0);
    expect_store("full_scale", 16'h9999, 1'b0);
    count_edges(1, 2, 2);
    repeat (3) step();
    check("overflow_of", 64'(of_o), 64'd1);
    expect_store("overflow", 16'h9999, 1'b1);
    en = 1'b0;
    do_clear();
    step();
    check("of_cleared", 64'(of_o), 64'd0);
    check("latch_holds_after_clear", 64'(data_of), 64'd1);
    expect_store("after_of_clear", 16'h0000, 1'b0);

    // Reset mid-measurement discards the partial count.
    en = 1'b1;
    count_edges(5, 2, 2);
    rst = 1'b1; step();
    rst = 1'b0; en = 1'b0;
    repeat (3) step();
    expect_store("reset_mid", 16'h0000, 1'b0);

    // Random traffic against the model.
    begin
      int phase_left = 2;
      for (int i = 0; i < 4000; i++) begin
        if (phase_left == 0) begin
          cpx = ~cpx;
          phase_left = $urandom_range(2, 6);
        end
        phase_left--;
        rst = ($urandom_range(0, 499) == 0);
        if ($urandom_range(0, 29) == 0) en = ~en;
        clr = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 7) == 0) st = ~st;
        step();
      end
      rst = 1'b0; clr = 1'b0; st = 1'b0; en = 1'b0;
      step();
      $display("random phase done: Data_BCD=%h OF=%0d", data_bcd, of_o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/freq_count_latch.md
Name: freq_count_latch

Overview:
- Measurement counter and display latch downstream of the frequency-divider/timing-control stage.
- Synchronises the external test signal CPx and counts its rising edges in BCD while C_Enable is high.
- Clears on C_Clear and captures the count into an output latch on C_Store, for the display/decoder stage.
- Produces the live overflow flag OF, which feeds back to the timing-control stage for range selection.

Parameters:
- DIGITS, 6, number of BCD decades in counter and latch (max count 10^DIGITS-1).
- SYNC_STAGES, 2, flip-flop stages in the CPx synchroniser (minimum 2).

Ports:
- CLK_50 input 1 — 50 MHz system clock; all logic on its rising edge.
- RST input 1 — synchronous, active-high reset.
- CPx input 1 — external signal under measurement; asynchronous to CLK_50.
- C_Enable input 1 — count gate, level, CLK_50-synchronous.
- C_Clear input 1 — counter clear, level, CLK_50-synchronous.
- C_Store input 1 — store request, level, CLK_50-synchronous; may stay high for many cycles.
- OF output 1 — live sticky overflow of the running counter.
- Data_BCD output 4*DIGITS — latched count; digit 0 = LSD in bits [3:0].
- Data_OF output 1 — overflow state captured with Data_BCD.
- Data_Valid output 1 — one-cycle pulse when the latch updates.

Behaviour:
- Reset: on a CLK_50 edge with RST=1, every register goes to 0:
  - synchroniser, edge detector, counter, OF, Data_BCD, Data_OF, Data_Valid, store-edge register.
  - RST overrides all other inputs in that cycle.
- Synchroniser:
  - CPx passes through SYNC_STAGES flops, then one more flop for edge detection.
  - cpx_rise = sync_out & ~sync_prev; one CLK_50 cycle wide.
  - Latency CPx rising edge -> cpx_rise: SYNC_STAGES+1 cycles.
  - Guaranteed input range: CPx high and low times each >= 2 CLK_50 periods (CPx <= 12.5 MHz).
- Counter (BCD, DIGITS decades):
  - Increments when cpx_rise & C_Enable & ~C_Clear in the same cycle.
  - Digit k increments only when digits 0..k-1 are all 9; each digit wraps 9 -> 0.
  - Digit values 10..15 are never produced.
  - At all-9s, an increment leaves the counter at all-9s (saturate) and sets OF=1.
  - OF is sticky until C_Clear or RST.
  - Increment to exactly all-9s from a lower value does not set OF.
- Clear:
  - C_Clear=1 sets counter and OF to 0 in the next cycle.
  - Clear wins over a simultaneous increment; holding C_Clear keeps the counter at 0.
  - C_Clear does not affect Data_BCD, Data_OF or Data_Valid.
- Store:
  - store_rise = C_Store & ~C_Store_d (registered); a long C_Store level triggers exactly once.
  - On store_rise: Data_BCD <= counter, Data_OF <= OF, Data_Valid=1 for the next cycle only.
  - Store/increment in the same cycle: the latch captures the pre-increment value.
  - Store/clear in the same cycle: the latch captures the pre-clear value. The timing stage issues C_Store before C_Clear; this ordering makes overlap safe.
  - Data_BCD and Data_OF hold between stores.
- Gate closure:
  - cpx_rise arriving while C_Enable=0 is discarded, not deferred.
  - Edges inside the synchroniser when C_Enable falls are counted only if their cpx_rise cycle still sees C_Enable=1.
- Reset mid-measurement: counter and latch zeroed. Partial counts are never stored after RST.
- Size: no other state. RTL estimate 150-250 lines including the BCD carry chain generate loop.

Test Plan:
- Reset: RST=1 for 3 cycles with CPx toggling and C_Enable=1 -> Data_BCD=0, OF=0, Data_Valid=0; counter stays 0 while RST=1.
- Basic count: C_Clear pulse, C_Enable=1 for 137 CPx periods (CPx = 1 MHz), C_Enable=0, C_Store held 5 cycles -> Data_BCD=0x000137, Data_OF=0, exactly one Data_Valid pulse.
- Decade carry: count 999 edges then 1 more -> internal value 0x001000; store -> Data_BCD=0x001000, no digit ever holds 0xA-0xF (assertion).
- Overflow: 999999 edges -> store shows 0x999999, Data_OF=0. One more edge -> OF=1, counter stays 0x999999, store gives Data_OF=1. C_Clear -> OF=0.
- Gate discard: CPx rising edge placed so cpx_rise coincides with the first cycle of C_Enable=0 -> that edge not counted (count N, not N+1).
- Simultaneous events:
  - C_Store and C_Clear rising together with counter=0x000042 -> Data_BCD=0x000042, counter=0 next cycle.
  - Increment and store in the same cycle -> latch holds the pre-increment value.
